// File: rtl/calc_pkg.sv
// Shared constants, port FSM states and command classification for calc_multiport.
// Command codes are 32-bit so the classifier works for any command width up to 32.
package calc_pkg;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_SUCC = 2'd1;
   localparam logic [1:0] RESP_INOF = 2'd2;
   localparam logic [1:0] RESP_IERR = 2'd3;

   localparam int unsigned CMD_NOP = 32'd0;
   localparam int unsigned CMD_ADD = 32'd1;
   localparam int unsigned CMD_SUB = 32'd2;
   localparam int unsigned CMD_LSH = 32'd5;
   localparam int unsigned CMD_RSH = 32'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPB  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } port_state_e;

   typedef enum logic [1:0] {
      CLS_INV   = 2'd0,
      CLS_ARITH = 2'd1,
      CLS_SHIFT = 2'd2
   } cmd_class_e;

   function automatic cmd_class_e classify_cmd(input int unsigned cmd);
      cmd_class_e cls;
      case (cmd)
         CMD_ADD, CMD_SUB: cls = CLS_ARITH;
         CMD_LSH, CMD_RSH: cls = CLS_SHIFT;
         default:          cls = CLS_INV;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/calc_port_fifo.sv
// FIFO of port IDs for one execution unit. Any set of ports may push in one cycle;
// they are appended in ascending port order behind the entries that survive the pop.
module calc_port_fifo #(
   parameter int DEPTH = 4,
   parameter int IDW   = 2,
   localparam int CNTW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DEPTH-1:0] push_i,
   input  logic             pop_i,
   output logic [IDW-1:0]   head_o,
   output logic             empty_o,
   output logic [CNTW-1:0]  count_o
);

   logic [IDW-1:0]  mem_q [DEPTH];
   logic [IDW-1:0]  mem_d [DEPTH];
   logic [CNTW-1:0] count_q;
   logic [CNTW-1:0] count_d;

   // Next contents: shift out the head on pop, then append pushes in port order.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (pop_i && (count_q != '0)) begin
         for (int e = 0; e < DEPTH - 1; e++) begin
            mem_d[e] = mem_q[e+1];
         end
         mem_d[DEPTH-1] = '0;
         count_d        = count_q - CNTW'(1);
      end else begin
         count_d = count_q;
      end
      for (int p = 0; p < DEPTH; p++) begin
         if (push_i[p]) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem_d[e] = (count_d == CNTW'(e)) ? IDW'(p) : mem_d[e];
            end
            count_d = count_d + CNTW'(1);
         end else begin
            count_d = count_d;
         end
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= '0;
         end
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[0];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/calc_multiport.sv
// Multi-port calculator: NPORTS request FSMs sharing one arithmetic and one shift unit,
// each unit serving its ports strictly in arrival order through a port-ID FIFO.
module calc_multiport
   import calc_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int DW     = 32,
   parameter int CW     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NPORTS*CW-1:0] req_cmd_in,
   input  logic [NPORTS*DW-1:0] req_data_in,
   output logic [NPORTS*2-1:0]  out_resp,
   output logic [NPORTS*DW-1:0] out_data
);

   localparam int IDW  = $clog2(NPORTS);
   localparam int SHW  = $clog2(DW);
   localparam int CNTW = $clog2(NPORTS + 1);

   port_state_e [NPORTS-1:0]         st_all;
   logic        [NPORTS-1:0][CW-1:0] cmd_all;
   logic        [NPORTS-1:0][DW-1:0] op1_all;
   logic        [NPORTS-1:0][DW-1:0] op2_all;
   logic        [NPORTS-1:0]         arith_push;
   logic        [NPORTS-1:0]         shift_push;

   logic [IDW-1:0]  arith_head;
   logic [IDW-1:0]  shift_head;
   logic            arith_empty;
   logic            shift_empty;
   logic [CNTW-1:0] unused_arith_count;
   logic [CNTW-1:0] unused_shift_count;

   logic            arith_exec;
   logic [1:0]      arith_resp;
   logic [DW-1:0]   arith_data;
   logic [DW:0]     arith_sum;
   logic            shift_exec;
   logic [DW-1:0]   shift_data;
   logic [SHW-1:0]  shift_amt;

   calc_port_fifo #(.DEPTH(NPORTS), .IDW(IDW)) u_arith_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (arith_push),
      .pop_i   (arith_exec),
      .head_o  (arith_head),
      .empty_o (arith_empty),
      .count_o (unused_arith_count)
   );

   calc_port_fifo #(.DEPTH(NPORTS), .IDW(IDW)) u_shift_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (shift_push),
      .pop_i   (shift_exec),
      .head_o  (shift_head),
      .empty_o (shift_empty),
      .count_o (unused_shift_count)
   );

   // Arithmetic unit: executes the head port only once its second operand is latched.
   always_comb begin
      arith_exec = !arith_empty && (st_all[arith_head] == ST_WAIT);
      arith_sum  = {1'b0, op1_all[arith_head]} + {1'b0, op2_all[arith_head]};
      arith_resp = RESP_SUCC;
      arith_data = '0;
      if (32'(cmd_all[arith_head]) == CMD_SUB) begin
         if (op2_all[arith_head] > op1_all[arith_head]) begin
            arith_resp = RESP_INOF;
            arith_data = '0;
         end else begin
            arith_resp = RESP_SUCC;
            arith_data = op1_all[arith_head] - op2_all[arith_head];
         end
      end else begin
         if (arith_sum[DW]) begin
            arith_resp = RESP_INOF;
            arith_data = '0;
         end else begin
            arith_resp = RESP_SUCC;
            arith_data = arith_sum[DW-1:0];
         end
      end
   end

   // Shift unit: only the low log2(DW) bits of op2 form the amount, so it cannot overflow.
   always_comb begin
      shift_exec = !shift_empty && (st_all[shift_head] == ST_WAIT);
      shift_amt  = op2_all[shift_head][SHW-1:0];
      if (32'(cmd_all[shift_head]) == CMD_LSH) begin
         shift_data = op1_all[shift_head] << shift_amt;
      end else begin
         shift_data = op1_all[shift_head] >> shift_amt;
      end
   end

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      port_state_e st_q, st_d;
      logic [CW-1:0] cmd_q, cmd_d;
      logic [DW-1:0] op1_q, op1_d, op2_q, op2_d;
      logic [1:0]    resp_q, resp_d;
      logic [DW-1:0] data_q, data_d;
      logic [CW-1:0] cmd_in;
      logic [DW-1:0] data_in;
      cmd_class_e    in_cls, lat_cls;
      logic          accept, go_arith, go_shift;

      assign cmd_in   = req_cmd_in[p*CW +: CW];
      assign data_in  = req_data_in[p*DW +: DW];
      assign in_cls   = classify_cmd(32'(cmd_in));
      assign lat_cls  = classify_cmd(32'(cmd_q));
      assign accept   = ((st_q == ST_IDLE) || (st_q == ST_RESP)) && (32'(cmd_in) != CMD_NOP);
      assign go_arith = arith_exec && (arith_head == IDW'(p));
      assign go_shift = shift_exec && (shift_head == IDW'(p));

      // Invalid commands are never queued; they resolve in the operand-B cycle.
      assign arith_push[p] = accept && (in_cls == CLS_ARITH);
      assign shift_push[p] = accept && (in_cls == CLS_SHIFT);

      // Port FSM next state and next output registers.
      always_comb begin
         st_d   = st_q;
         cmd_d  = cmd_q;
         op1_d  = op1_q;
         op2_d  = op2_q;
         resp_d = RESP_NONE;
         data_d = '0;
         case (st_q)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  st_d  = ST_OPB;
                  cmd_d = cmd_in;
                  op1_d = data_in;
               end else begin
                  st_d = ST_IDLE;
               end
            end
            ST_OPB: begin
               op2_d = data_in;
               if (lat_cls == CLS_INV) begin
                  st_d   = ST_RESP;
                  resp_d = RESP_INOF;
               end else begin
                  st_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (go_arith) begin
                  st_d   = ST_RESP;
                  resp_d = arith_resp;
                  data_d = arith_data;
               end else if (go_shift) begin
                  st_d   = ST_RESP;
                  resp_d = RESP_SUCC;
                  data_d = shift_data;
               end else begin
                  st_d = ST_WAIT;
               end
            end
            default: st_d = ST_IDLE;
         endcase
      end

      // Port state, latched request and registered response.
      always_ff @(posedge clk) begin
         if (reset) begin
            st_q   <= ST_IDLE;
            cmd_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            resp_q <= RESP_NONE;
            data_q <= '0;
         end else begin
            st_q   <= st_d;
            cmd_q  <= cmd_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            resp_q <= resp_d;
            data_q <= data_d;
         end
      end

      assign st_all[p]             = st_q;
      assign cmd_all[p]            = cmd_q;
      assign op1_all[p]            = op1_q;
      assign op2_all[p]            = op2_q;
      assign out_resp[p*2 +: 2]    = resp_q;
      assign out_data[p*DW +: DW]  = data_q;
   end

endmodule

// File: tb/tb_calc_multiport.sv
// Randomised bench for calc_multiport against a transaction-level model with per-unit
// FCFS queues; directed cases from the plan go through the same per-cycle checking.
module tb_calc_multiport;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NP*CW-1:0]  req_cmd_in;
   logic [NP*DW-1:0]  req_data_in;
   logic [NP*2-1:0]   out_resp;
   logic [NP*DW-1:0]  out_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 0 = free (idle or presenting a result), 1 = awaiting op2, 2 = queued on a unit.
   int          mst   [NP];
   int          mcmd  [NP];
   logic [31:0] mop1  [NP];
   logic [31:0] mop2  [NP];
   logic [1:0]  eresp [NP];
   logic [31:0] edata [NP];
   int          aq [$];
   int          sq [$];

   int          c_cmd [NP];
   logic [31:0] c_dat [NP];

   calc_multiport #(.NPORTS(NP), .DW(DW), .CW(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unit_of(input int cmd);
      if (cmd == 1 || cmd == 2) return 1;
      if (cmd == 5 || cmd == 6) return 2;
      return 0;
   endfunction

   task automatic exec_req(input int p);
      longint unsigned a = 64'(mop1[p]);
      longint unsigned b = 64'(mop2[p]);
      longint unsigned r = 64'd0;
      eresp[p] = 2'd1;
      case (mcmd[p])
         1: r = a + b;
         2: r = (b > a) ? 64'd0 : a - b;
         5: r = (a << (b % 64'd32)) & 64'hFFFF_FFFF;
         default: r = a >> (b % 64'd32);
      endcase
      if ((mcmd[p] == 1 && r > 64'hFFFF_FFFF) || (mcmd[p] == 2 && b > a)) begin
         eresp[p] = 2'd2;
         r        = 64'd0;
      end
      edata[p] = r[31:0];
   endtask

   task automatic model_edge();
      int snap [NP];
      int h;
      for (int p = 0; p < NP; p++) begin
         snap[p]  = mst[p];
         eresp[p] = 2'd0;
         edata[p] = 32'd0;
      end
      if (reset) begin
         for (int p = 0; p < NP; p++) mst[p] = 0;
         aq.delete();
         sq.delete();
         return;
      end
      if (aq.size() > 0 && snap[aq[0]] == 2) begin
         h = aq.pop_front();
         exec_req(h);
         mst[h] = 0;
      end
      if (sq.size() > 0 && snap[sq[0]] == 2) begin
         h = sq.pop_front();
         exec_req(h);
         mst[h] = 0;
      end
      for (int p = 0; p < NP; p++) begin
         if (snap[p] == 1) begin
            mop2[p] = c_dat[p];
            if (unit_of(mcmd[p]) == 0) begin
               eresp[p] = 2'd2;
               mst[p]   = 0;
            end else begin
               mst[p] = 2;
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (snap[p] == 0 && c_cmd[p] != 0) begin
            mcmd[p] = c_cmd[p];
            mop1[p] = c_dat[p];
            mst[p]  = 1;
            if (unit_of(c_cmd[p]) == 1) aq.push_back(p);
            if (unit_of(c_cmd[p]) == 2) sq.push_back(p);
         end
      end
   endtask

   // Drive the staged inputs, clock one edge, update the model, compare every port.
   task automatic step();
      for (int p = 0; p < NP; p++) begin
         req_cmd_in[p*CW +: CW]  = CW'(c_cmd[p]);
         req_data_in[p*DW +: DW] = c_dat[p];
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         check_eq($sformatf("port%0d resp", p), 32'(out_resp[p*2 +: 2]), 32'(eresp[p]));
         check_eq($sformatf("port%0d data", p), out_data[p*DW +: DW], edata[p]);
      end
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < NP; p++) begin
         c_cmd[p] = 0;
         c_dat[p] = 32'd0;
      end
   endtask

   task automatic do_req(input int p, input int cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed, input string tag);
      c_cmd[p] = cmd;
      c_dat[p] = a;
      step();
      c_cmd[p] = 0;
      c_dat[p] = b;
      step();
      c_dat[p] = 32'd0;
      if (unit_of(cmd) == 0) begin
         check_eq({tag, " resp"}, 32'(out_resp[p*2 +: 2]), 32'(er));
         check_eq({tag, " data"}, out_data[p*DW +: DW], ed);
      end
      step();
      if (unit_of(cmd) != 0) begin
         check_eq({tag, " resp"}, 32'(out_resp[p*2 +: 2]), 32'(er));
         check_eq({tag, " data"}, out_data[p*DW +: DW], ed);
      end
      step();
      step();
   endtask

   function automatic int rand_cmd();
      case ($urandom_range(0, 9))
         0, 1:    return 0;
         2, 3:    return 1;
         4:       return 2;
         5:       return 5;
         6:       return 6;
         7:       return 3;
         8:       return int'($urandom_range(7, 15));
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 40));
         1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      for (int p = 0; p < NP; p++) mst[p] = 0;
      idle_inputs();
      reset       = 1'b1;
      req_cmd_in  = '0;
      req_data_in = '0;
      step();
      step();
      reset = 1'b0;
      step();

      do_req(0, 1, 32'd5,          32'd7,  2'd1, 32'd12, "add 5+7");
      do_req(1, 1, 32'hFFFF_FFFF,  32'd1,  2'd2, 32'd0,  "add overflow");
      do_req(2, 2, 32'd3,          32'd5,  2'd2, 32'd0,  "sub underflow");
      do_req(3, 2, 32'd5,          32'd3,  2'd1, 32'd2,  "sub 5-3");
      do_req(0, 2, 32'd9,          32'd9,  2'd1, 32'd0,  "sub equal");
      do_req(1, 5, 32'd1,          32'd35, 2'd1, 32'd8,  "lsh 1<<35");
      do_req(2, 6, 32'h8000_0000,  32'd31, 2'd1, 32'd1,  "rsh 31");
      do_req(3, 3, 32'd4,          32'd4,  2'd2, 32'd0,  "cmd 3 invalid");

      // Three ADDs contend while a shift on port 3 proceeds in parallel.
      c_cmd = '{1, 1, 1, 5};
      c_dat = '{32'd10, 32'd20, 32'd30, 32'd3};
      step();
      c_cmd = '{0, 0, 0, 0};
      c_dat = '{32'd1, 32'd2, 32'd3, 32'd2};
      step();
      idle_inputs();
      repeat (6) step();

      // Back-to-back on port 2: new command presented during its result cycle.
      c_cmd[2] = 1; c_dat[2] = 32'd100; step();
      c_cmd[2] = 0; c_dat[2] = 32'd1;   step();
      c_dat[2] = 32'd0;                 step();
      c_cmd[2] = 2; c_dat[2] = 32'd50;  step();
      c_cmd[2] = 0; c_dat[2] = 32'd8;   step();
      idle_inputs();
      repeat (4) step();

      // Reset while three ports wait on the arithmetic unit.
      c_cmd = '{1, 1, 1, 0};
      c_dat = '{32'd1, 32'd2, 32'd3, 32'd0};
      step();
      c_cmd = '{0, 0, 0, 0};
      step();
      reset = 1'b1;
      idle_inputs();
      step();
      reset = 1'b0;
      repeat (5) step();
      do_req(1, 1, 32'd40, 32'd2, 2'd1, 32'd42, "add after reset");

      for (int cyc = 0; cyc < 600; cyc++) begin
         reset = ($urandom_range(0, 149) == 0);
         for (int p = 0; p < NP; p++) begin
            if (mst[p] == 0) begin
               c_cmd[p] = rand_cmd();
               c_dat[p] = rand_data();
            end else begin
               c_cmd[p] = int'($urandom_range(0, 15));
               c_dat[p] = rand_data();
            end
         end
         step();
      end
      reset = 1'b0;
      idle_inputs();
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
